// File: rtl/csa_accumulator.sv
// Carry-save accumulator: folds TERMS operands into sum/carry registers, then
// resolves the carry-propagate add CHUNK bits per cycle. `CSA_ACC_SIGNED_EN selects sign extension.
module csa_accumulator #(
  parameter int WIDTH = 16,
  parameter int TERMS = 4,
  parameter int CHUNK = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH+$clog2(TERMS)-1:0]      out_data,
  output logic                                busy
);

  localparam int ACC_W = WIDTH + $clog2(TERMS);
  localparam int NCH   = ACC_W / CHUNK;
  localparam int CW    = $clog2(TERMS);
  localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUT} state_t;

  state_t             state;
  logic [ACC_W-1:0]   s, c, r;
  logic               cy;
  logic [CW-1:0]      cnt;
  logic [KW-1:0]      k;

  logic [ACC_W-1:0]   x_ext, s_next, c_next;
  logic [CHUNK:0]     chunk;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
`ifdef CSA_ACC_SIGNED_EN
    x_ext = {{(ACC_W-WIDTH){in_data[WIDTH-1]}}, in_data};
`else
    x_ext = {{(ACC_W-WIDTH){1'b0}}, in_data};
`endif
    s_next = s ^ c ^ x_ext;
    c_next = ((s & c) | (s & x_ext) | (c & x_ext)) << 1;
    // s and c shift right during RESOLVE, so the active chunk is always the low CHUNK bits.
    chunk  = {1'b0, s[CHUNK-1:0]} + {1'b0, c[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy};
  end

  assign in_ready = (state == ACCUM) && !clear;
  assign busy     = (state != ACCUM);
  assign out_data = r;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      r         <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            s <= s_next;
            c <= c_next;
            if (cnt == CW'(TERMS-1)) begin
              cnt   <= '0;
              k     <= '0;
              cy    <= 1'b0;
              state <= RESOLVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESOLVE: begin
          // Resolved chunks enter at the top; after NCH cycles chunk 0 sits at bit 0.
          r  <= (r >> CHUNK) | (ACC_W'(chunk[CHUNK-1:0]) << (ACC_W-CHUNK));
          s  <= s >> CHUNK;
          c  <= c >> CHUNK;
          cy <= chunk[CHUNK];
          if (k == KW'(NCH-1)) begin
            k         <= '0;
            state     <= OUT;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            s         <= '0;
            c         <= '0;
            cnt       <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator (WIDTH=16, TERMS=4, CHUNK=6, NCH=3).
// Expected values adapt to whether CSA_ACC_SIGNED_EN is defined for the build.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [17:0] out_data;

  int checks   = 0;
  int failures = 0;

  csa_accumulator #(.WIDTH(16), .TERMS(4), .CHUNK(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  // Called #1 after the edge that accepted the final operand.
  task automatic expect_result(input string tag, input logic [31:0] exp);
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_lat2"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_lat3"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_done_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Mixed operands: 0xFFFF is -1 signed, 65535 unsigned.
    send4(16'h0001, 16'h0002, 16'h0003, 16'hFFFF);
`ifdef CSA_ACC_SIGNED_EN
    expect_result("mix", 32'h00005);
`else
    expect_result("mix", 32'h10005);
`endif
    consume("mix");

    send4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    expect_result("max_pos", 32'h1FFFC);
    consume("max_pos");

    // 4*0xFFFF = 0x3FFFC unsigned; 4*(-1) = -4 = 0x3FFFC in 18-bit two's complement.
    send4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    expect_result("all_ones", 32'h3FFFC);
    consume("all_ones");

    // Hold result with out_ready low while offering an operand that must be ignored.
    send4(16'd9, 16'd9, 16'd9, 16'd9);
    expect_result("hold", 32'h00024);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data",  32'(out_data),  32'h00024);
      check("hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    in_data  = '0;
    consume("hold");
    send4(16'd1, 16'd1, 16'd1, 16'd1);
    expect_result("after_hold", 32'h00004);
    consume("after_hold");

    // Clear during RESOLVE cycle 1 aborts the result.
    send4(16'd9, 16'd9, 16'd9, 16'd9);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy",  32'(busy),      32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("clr_no_valid", 32'(out_valid), 32'd0);
    end
    send4(16'd5, 16'd5, 16'd5, 16'd5);
    expect_result("after_clr", 32'h00014);
    consume("after_clr");

    // Clear with a partial set discards it and gates in_ready.
    send(16'd100);
    send(16'd100);
    clear = 1'b1;
    #1;
    check("clr_gate_ready", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0;
    send4(16'd1, 16'd2, 16'd3, 16'd4);
    expect_result("after_partial_clr", 32'h0000A);
    consume("after_partial_clr");

    // Asynchronous reset mid-OUT.
    send4(16'd2, 16'd2, 16'd2, 16'd2);
    expect_result("pre_rst", 32'h00008);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready),  32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send4(16'd1, 16'd2, 16'd3, 16'd4);
    expect_result("post_rst", 32'h0000A);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The module SHALL have parameter TERMS, default 4, giving the operands per result; legal values are powers of two and 2 or more.
REQ-003 The module SHALL have parameter CHUNK, default 6, giving the bits resolved per cycle; CHUNK SHALL divide ACC_W, where ACC_W = WIDTH + $clog2(TERMS) and NCH = ACC_W/CHUNK.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port clear, input, 1 bit: synchronous abort and restart.
REQ-007 The module SHALL have port in_valid, input, 1 bit: operand offered.
REQ-008 The module SHALL have port in_ready, output, 1 bit: operand can be accepted.
REQ-009 The module SHALL have port in_data, input, WIDTH bits: operand.
REQ-010 The module SHALL have port out_valid, output, 1 bit: result available.
REQ-011 The module SHALL have port out_ready, input, 1 bit: result consumed.
REQ-012 The module SHALL have port out_data, output, ACC_W bits: resolved sum.
REQ-013 The module SHALL have port busy, output, 1 bit: high when the state is not ACCUM.

Function
REQ-014 The FSM SHALL have three states: ACCUM, RESOLVE and OUT.
- ACCUM to RESOLVE on acceptance of the TERMS-th operand.
- RESOLVE to OUT after NCH cycles.
- OUT to ACCUM on out_valid & out_ready.
REQ-015 An operand SHALL be accepted on an edge with in_valid & in_ready; in_ready SHALL be 1 only in ACCUM with clear low.
REQ-016 Each accepted operand x SHALL be extended to ACC_W bits and folded into the registers as follows, with all arithmetic modulo 2^ACC_W:
- S' = S ^ C ^ x
- C' = ((S&C)|(S&x)|(C&x)) << 1
REQ-017 An operand counter SHALL count accepted operands modulo TERMS and SHALL wrap to 0 on the TERMS-th acceptance.
REQ-018 RESOLVE cycle k (k = 0..NCH-1) SHALL perform one chunk of the carry-propagate add:
- R[k*CHUNK +: CHUNK] = S chunk + C chunk + cy.
- cy is a 1-bit register, 0 at the start of RESOLVE; its final carry-out SHALL be discarded.
REQ-019 out_valid SHALL go high after the NCH-th edge following the edge that accepted the final operand.
REQ-020 out_data SHALL equal the exact modular sum of the TERMS operands.
REQ-021 In OUT, out_valid and out_data SHALL hold stable until out_ready is sampled high.
REQ-022 On the OUT handshake edge, S, C and the counter SHALL clear; no operand SHALL be accepted on that edge.
REQ-023 clear=1 at an edge SHALL force state ACCUM, S=C=0, counter=0, out_valid=0 and cy=0 in any state, with priority over every handshake.
REQ-024 in_valid and in_data SHALL be ignored outside ACCUM.
REQ-025 out_ready SHALL be ignored outside OUT.

Reset
REQ-026 When rst_n is low, the module SHALL asynchronously force state ACCUM, S=0, C=0, R=0, cy=0 and counter=0.
REQ-027 The outputs SHALL reset to out_valid=0, out_data=0, busy=0 and in_ready=1 (in_ready is combinational from state and clear).
REQ-028 Reset asserted mid-RESOLVE or mid-OUT SHALL discard the partial result, and no out_valid SHALL follow.

Configuration
REQ-029 The macro CSA_ACC_SIGNED_EN SHALL select operand extension:
- Defined: operands are two's complement and SHALL be sign-extended to ACC_W, and out_data is two's complement.
- Undefined: operands SHALL be zero-extended, and out_data is unsigned.

Verification
REQ-030 The bench SHALL cover these directed scenarios, each with WIDTH=16, TERMS=4, CHUNK=6, NCH=3:
- Signed build, operands 0x0001, 0x0002, 0x0003, 0xFFFF back-to-back -> out_data=0x00005, out_valid high 3 edges after the 4th accept.
- Unsigned build, same operands -> out_data=0x10005.
- Signed build, operands 0x7FFF x4 -> out_data=0x1FFFC; unsigned build, operands 0xFFFF x4 -> out_data=0x3FFFC.
- Result held with out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout; next set 1, 1, 1, 1 -> out_data=0x00004, proving S, C and the counter were cleared.
- clear asserted in RESOLVE cycle 1 -> no out_valid; next set 5, 5, 5, 5 -> out_data=0x00014.
- rst_n pulsed low mid-OUT -> out_valid drops immediately, in_ready=1 after release, and the counter restarts at 0.
